// File: rtl/dcache_if.sv
// Bus bundle between the datapath, the data cache and memory.
// The cache takes the slave view; the datapath and the memory model take the master view.
interface dcache_if;
    // Datapath side
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    // Memory side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with two-word blocks.
// On halt every dirty frame is written back in index order, then flushed is raised.
module dcache #(
    parameter int SETS = 16
) (
    input  logic     CLK,
    input  logic     nRST,
    dcache_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic                flushed_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS][2];

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic                req_sel;
    logic                req, hit, store_hit, xfer_done, last_set, word_sel;
    logic                unused_bits;

    assign req_tag     = bus.dmemaddr[31 -: TAG_W];
    assign req_idx     = bus.dmemaddr[3 +: IDX_W];
    assign req_sel     = bus.dmemaddr[2];
    assign unused_bits = ^bus.dmemaddr[1:0];

    assign req       = bus.dmemREN | bus.dmemWEN;
    assign hit       = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign xfer_done = !bus.dwait;
    assign last_set  = (cnt_q == IDX_W'(SETS - 1));

    // halt wins over any pending request, so no hit is reported on the halt cycle
    assign bus.dhit     = (state_q == IDLE) && !bus.halt && hit;
    assign store_hit    = bus.dhit && bus.dmemWEN;
    assign bus.dmemload = (bus.dhit && bus.dmemREN) ? data_q[req_idx][req_sel] : '0;
    assign bus.flushed  = flushed_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and block ordering cannot create races.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
            flushed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.halt) begin
                        state_q <= FLUSH;
                        cnt_q   <= '0;
                    end else if (store_hit) begin
                        dirty_q[req_idx] <= 1'b1;
                    end else if (req && !hit) begin
                        state_q <= dirty_q[req_idx] ? WB0 : LD0;
                    end
                end
                WB0: if (xfer_done) state_q <= WB1;
                WB1: if (xfer_done) state_q <= LD0;
                LD0: if (xfer_done) state_q <= LD1;
                LD1: begin
                    if (xfer_done) begin
                        state_q          <= IDLE;
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (dirty_q[cnt_q]) begin
                        state_q <= FWB0;
                    end else if (last_set) begin
                        state_q   <= DONE;
                        flushed_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                FWB0: if (xfer_done) state_q <= FWB1;
                FWB1: begin
                    if (xfer_done) begin
                        dirty_q[cnt_q] <= 1'b0;
                        if (last_set) begin
                            state_q   <= DONE;
                            flushed_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + IDX_W'(1);
                            state_q <= FLUSH;
                        end
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, which keeps them plain RAM.
    always_ff @(posedge CLK) begin
        if (state_q == LD0 && xfer_done) begin
            data_q[req_idx][0] <= bus.dload;
        end
        if (state_q == LD1 && xfer_done) begin
            data_q[req_idx][1] <= bus.dload;
            tag_q[req_idx]     <= req_tag;
        end
        if (store_hit) begin
            data_q[req_idx][req_sel] <= bus.dmemstore;
        end
    end

    assign word_sel = (state_q == WB1) || (state_q == LD1) || (state_q == FWB1);

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        case (state_q)
            WB0, WB1: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {tag_q[req_idx], req_idx, word_sel, 2'b00};
                bus.dstore = data_q[req_idx][word_sel];
            end
            LD0, LD1: begin
                bus.dREN  = 1'b1;
                bus.daddr = {req_tag, req_idx, word_sel, 2'b00};
            end
            FWB0, FWB1: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {tag_q[cnt_q], cnt_q, word_sel, 2'b00};
                bus.dstore = data_q[cnt_q][word_sel];
            end
            default: ;
        endcase
    end
endmodule
